// File: rtl/flags_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : flags_unit_pkg
//  Description : Shared opcodes package for the flags unit: flag bit indices,
//                condition-code encoding and the default saved-flag depth.
//  Revision    : 1.0 - initial release
// ============================================================================
package flags_unit_pkg;

    // Bit positions of the individual flags inside the 4-bit flag vector
    localparam int FLAGS_V = 0;
    localparam int FLAGS_C = 1;
    localparam int FLAGS_Z = 2;
    localparam int FLAGS_N = 3;

    // Default number of saved-flag entries
    localparam int STACK_DEPTH_DEFAULT = 4;

    // Condition select encoding
    typedef enum logic [3:0] {
        COND_EQ = 4'd0,
        COND_NE = 4'd1,
        COND_CS = 4'd2,
        COND_CC = 4'd3,
        COND_MI = 4'd4,
        COND_PL = 4'd5,
        COND_VS = 4'd6,
        COND_VC = 4'd7,
        COND_HI = 4'd8,
        COND_LS = 4'd9,
        COND_GE = 4'd10,
        COND_LT = 4'd11,
        COND_GT = 4'd12,
        COND_LE = 4'd13,
        COND_AL = 4'd14,
        COND_NV = 4'd15
    } cond_t;

endpackage : flags_unit_pkg
`default_nettype wire

// File: rtl/flags_unit_cond_eval.sv
`default_nettype none
// ============================================================================
//  Module      : cond_eval
//  Description : Purely combinational condition evaluator. Decodes a cond_t
//                select against a flag vector and returns the hit bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module cond_eval
    import flags_unit_pkg::*;
(
    input  logic [3:0] Flags,
    input  cond_t      CondCode,
    output logic       Hit
);

    logic w_z;
    logic w_n;
    logic w_c;
    logic w_v;

    assign w_z = Flags[FLAGS_Z];
    assign w_n = Flags[FLAGS_N];
    assign w_c = Flags[FLAGS_C];
    assign w_v = Flags[FLAGS_V];

    // Decode the selected condition from the individual flag bits
    always_comb begin
        Hit = 1'b0;
        case (CondCode)
            COND_EQ: Hit = w_z;
            COND_NE: Hit = ~w_z;
            COND_CS: Hit = w_c;
            COND_CC: Hit = ~w_c;
            COND_MI: Hit = w_n;
            COND_PL: Hit = ~w_n;
            COND_VS: Hit = w_v;
            COND_VC: Hit = ~w_v;
            COND_HI: Hit = w_c & ~w_z;
            COND_LS: Hit = ~w_c | w_z;
            COND_GE: Hit = (w_n == w_v);
            COND_LT: Hit = (w_n != w_v);
            COND_GT: Hit = ~w_z & (w_n == w_v);
            COND_LE: Hit = w_z | (w_n != w_v);
            COND_AL: Hit = 1'b1;
            COND_NV: Hit = 1'b0;
            default: Hit = 1'b0;
        endcase
    end

endmodule : cond_eval
`default_nettype wire

// File: rtl/flags_unit.sv
`default_nettype none
// ============================================================================
//  Module      : flags_unit
//  Description : Processor flag register with registered condition
//                evaluation and an optional saved-flag stack used on
//                interrupt entry/exit.
//                Build option: define FLAGS_STACK_EN to include the stack;
//                without it Push/Pop are ignored and the stack reports empty.
//  Revision    : 1.0 - initial release
// ============================================================================
module flags_unit
    import flags_unit_pkg::*;
#(
    parameter int STACK_DEPTH = STACK_DEPTH_DEFAULT
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [3:0] AluFlags,
    input  logic       FlagsWe,
    input  logic [3:0] CondCode,
    input  logic       CondValid,
    input  logic       Push,
    input  logic       Pop,
    output logic [3:0] Flags,
    output logic       CarryOut,
    output logic       CondTrue,
    output logic       CondDone,
    output logic       StackFull,
    output logic       StackEmpty,
    output logic       StackErr
);

    logic [3:0] r_flags;
    logic       r_cond_true;
    logic       r_cond_done;
    logic       w_hit;
    logic       w_pop_ok;
    logic [3:0] w_pop_data;

    // Condition is always evaluated against the registered flags, so a
    // same-cycle FlagsWe never leaks into the result.
    cond_eval u_cond_eval (
        .Flags    (r_flags),
        .CondCode (cond_t'(CondCode)),
        .Hit      (w_hit)
    );

`ifdef FLAGS_STACK_EN
    localparam int c_CNT_W = $clog2(STACK_DEPTH + 1);
    localparam int c_IDX_W = $clog2(STACK_DEPTH);

    logic [3:0]         r_stack [STACK_DEPTH];
    logic [c_CNT_W-1:0] r_count;
    logic               r_stack_err;
    logic               w_full;
    logic               w_empty;
    logic               w_push_ok;
    logic               w_err_evt;
    logic [c_IDX_W-1:0] w_push_idx;
    logic [c_IDX_W-1:0] w_top_idx;

    assign w_full     = (r_count == c_CNT_W'(STACK_DEPTH));
    assign w_empty    = (r_count == '0);
    assign w_push_ok  = Push & ~Pop & ~w_full;
    assign w_pop_ok   = Pop & ~Push & ~w_empty;
    // Simultaneous push/pop, overflow and underflow are all misuse
    assign w_err_evt  = (Push & Pop) | (Push & ~Pop & w_full) | (Pop & ~Push & w_empty);
    assign w_push_idx = c_IDX_W'(r_count);
    assign w_top_idx  = c_IDX_W'(r_count - c_CNT_W'(1));
    assign w_pop_data = r_stack[w_top_idx];

    // Stack storage: no reset needed, occupancy is tracked by r_count
    always_ff @(posedge Clock) begin
        if (!Reset && w_push_ok) begin
            r_stack[w_push_idx] <= r_flags;
        end
    end

    // Occupancy counter and sticky misuse flag
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_count     <= '0;
            r_stack_err <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_count <= r_count + c_CNT_W'(1);
            end else if (w_pop_ok) begin
                r_count <= r_count - c_CNT_W'(1);
            end
            if (w_err_evt) begin
                r_stack_err <= 1'b1;
            end
        end
    end

    assign StackFull  = w_full;
    assign StackEmpty = w_empty;
    assign StackErr   = r_stack_err;
`else
    logic [5:0] w_unused_cfg;

    assign w_unused_cfg = {Push, Pop, 4'(STACK_DEPTH)};
    assign w_pop_ok     = 1'b0;
    assign w_pop_data   = 4'h0;
    assign StackFull    = 1'b0;
    assign StackEmpty   = 1'b1;
    assign StackErr     = 1'b0;
`endif

    // Flag register: a successful pop wins over an ALU write
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_flags <= 4'h0;
        end else if (w_pop_ok) begin
            r_flags <= w_pop_data;
        end else if (FlagsWe) begin
            r_flags <= AluFlags;
        end
    end

    // Condition result register: one result per request, held when idle
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_cond_true <= 1'b0;
            r_cond_done <= 1'b0;
        end else begin
            r_cond_done <= CondValid;
            if (CondValid) begin
                r_cond_true <= w_hit;
            end
        end
    end

    assign Flags    = r_flags;
    assign CarryOut = r_flags[FLAGS_C];
    assign CondTrue = r_cond_true;
    assign CondDone = r_cond_done;

endmodule : flags_unit
`default_nettype wire
